// File: rtl/vect_operand_stage.sv
// vect_operand_stage: vector register file with lane-masked writeback bypass feeding the ID/EX register of the 4-lane vector ALU.
module vect_operand_stage #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_ctrl,
    input  logic [AW-1:0] id_ra,
    input  logic [AW-1:0] id_rb,
    input  logic [AW-1:0] id_rd,
    input  logic          id_we,
    input  logic          stall,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_data,
    input  logic [3:0]    wb_lane_mask,
    output logic          ex_valid,
    output logic [31:0]   operA,
    output logic [31:0]   operB,
    output logic [3:0]    CtrlFunc,
    output logic [AW-1:0] ex_rd,
    output logic          ex_we
);
    logic [31:0]   rf [NREG];
    logic [AW-1:0] ex_ra, ex_rb;
    logic [31:0]   wmask, rd_a, rd_b, hold_a, hold_b, wr_val;

    // Lane-granular merge: masked lanes take wb_data, the rest keep their value.
    always_comb begin
        wmask  = {{8{wb_lane_mask[3]}}, {8{wb_lane_mask[2]}}, {8{wb_lane_mask[1]}}, {8{wb_lane_mask[0]}}};
        wr_val = (rf[wb_addr] & ~wmask) | (wb_data & wmask);
        rd_a   = (wb_en && wb_addr == id_ra) ? (rf[id_ra] & ~wmask) | (wb_data & wmask) : rf[id_ra];
        rd_b   = (wb_en && wb_addr == id_rb) ? (rf[id_rb] & ~wmask) | (wb_data & wmask) : rf[id_rb];
        hold_a = (wb_en && wb_addr == ex_ra) ? (operA & ~wmask) | (wb_data & wmask) : operA;
        hold_b = (wb_en && wb_addr == ex_rb) ? (operB & ~wmask) | (wb_data & wmask) : operB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_addr] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            operA    <= '0;
            operB    <= '0;
            CtrlFunc <= '0;
            ex_rd    <= '0;
            ex_ra    <= '0;
            ex_rb    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
        end else if (stall) begin
            operA <= hold_a;
            operB <= hold_b;
        end else begin
            ex_valid <= id_valid;
            ex_we    <= id_we & id_valid;
            operA    <= rd_a;
            operB    <= rd_b;
            CtrlFunc <= id_ctrl;
            ex_rd    <= id_rd;
            ex_ra    <= id_ra;
            ex_rb    <= id_rb;
        end
    end
endmodule

// File: tb/tb_vect_operand_stage.sv
// tb_vect_operand_stage: directed plan cases plus random traffic checked against a lane-level reference model.
module tb_vect_operand_stage;
    logic        clk, rst;
    logic        id_valid, id_we, stall, flush, wb_en;
    logic [3:0]  id_ctrl, wb_lane_mask;
    logic [2:0]  id_ra, id_rb, id_rd, wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid, ex_we;
    logic [31:0] operA, operB;
    logic [3:0]  CtrlFunc;
    logic [2:0]  ex_rd;

    int total = 0;
    int bad = 0;

    logic [7:0]  m_rf [8][4];
    logic [7:0]  m_a [4];
    logic [7:0]  m_b [4];
    logic        m_valid, m_we;
    logic [3:0]  m_ctrl;
    logic [2:0]  m_rd, m_ra, m_rb;

    vect_operand_stage #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_ra(id_ra), .id_rb(id_rb),
        .id_rd(id_rd), .id_we(id_we), .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_lane_mask(wb_lane_mask), .ex_valid(ex_valid), .operA(operA), .operB(operB),
        .CtrlFunc(CtrlFunc), .ex_rd(ex_rd), .ex_we(ex_we)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] v [4]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) for (int l = 0; l < 4; l++) m_rf[r][l] = 0;
        for (int l = 0; l < 4; l++) begin m_a[l] = 0; m_b[l] = 0; end
        {m_valid, m_we, m_ctrl, m_rd, m_ra, m_rb} = '0;
    endtask

    task automatic check_all(input string p);
        chk({p, "_valid"}, 32'(ex_valid), 32'(m_valid));
        chk({p, "_we"}, 32'(ex_we), 32'(m_we));
        chk({p, "_opA"}, operA, pack(m_a));
        chk({p, "_opB"}, operB, pack(m_b));
        chk({p, "_ctrl"}, 32'(CtrlFunc), 32'(m_ctrl));
        chk({p, "_rd"}, 32'(ex_rd), 32'(m_rd));
    endtask

    // One clock: predict from the current inputs, take the edge, then compare.
    task automatic cyc(input string p);
        logic [7:0] ra_v [4];
        logic [7:0] rb_v [4];
        for (int l = 0; l < 4; l++) begin
            logic hit;
            hit = wb_en && wb_lane_mask[l];
            ra_v[l] = (hit && wb_addr == id_ra) ? wb_data[8*l +: 8] : m_rf[id_ra][l];
            rb_v[l] = (hit && wb_addr == id_rb) ? wb_data[8*l +: 8] : m_rf[id_rb][l];
        end
        if (flush) begin
            m_valid = 0; m_we = 0;
        end else if (stall) begin
            for (int l = 0; l < 4; l++) if (wb_en && wb_lane_mask[l]) begin
                if (wb_addr == m_ra) m_a[l] = wb_data[8*l +: 8];
                if (wb_addr == m_rb) m_b[l] = wb_data[8*l +: 8];
            end
        end else begin
            m_valid = id_valid; m_we = id_we && id_valid;
            m_a = ra_v; m_b = rb_v;
            m_ctrl = id_ctrl; m_rd = id_rd; m_ra = id_ra; m_rb = id_rb;
        end
        for (int l = 0; l < 4; l++) if (wb_en && wb_lane_mask[l]) m_rf[wb_addr][l] = wb_data[8*l +: 8];
        @(posedge clk);
        #1;
        check_all(p);
    endtask

    task automatic idle();
        {id_valid, id_we, stall, flush, wb_en} = '0;
        {id_ctrl, wb_lane_mask, id_ra, id_rb, id_rd, wb_addr} = '0;
        wb_data = '0;
    endtask

    task automatic rd_regs(input logic [2:0] a, input logic [2:0] b);
        id_valid = 1; id_ra = a; id_rb = b;
    endtask

    task automatic wb(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        wb_en = 1; wb_addr = a; wb_data = d; wb_lane_mask = m;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all("rst");
        rst = 0;

        rd_regs(3, 3);
        cyc("r3");
        chk("r3_opA", operA, 32'h0);
        chk("r3_valid", 32'(ex_valid), 32'h1);

        idle(); wb(2, 32'hA1B2C3D4, 4'b1111);
        cyc("wr2");
        idle(); rd_regs(2, 0);
        cyc("rd2");
        chk("full_write", operA, 32'hA1B2C3D4);

        idle(); wb(5, 32'hFFFFFFFF, 4'b1111);
        cyc("wr5");
        idle(); wb(5, 32'h11223344, 4'b0101); rd_regs(5, 5);
        cyc("byp5");
        chk("bypass_A", operA, 32'hFF22FF44);
        chk("bypass_B", operB, 32'hFF22FF44);
        idle(); rd_regs(5, 2);
        cyc("rd5");
        chk("array_5", operA, 32'hFF22FF44);

        idle(); wb(1, 32'h01020304, 4'b1111);
        cyc("wr1");
        idle(); rd_regs(1, 2); id_ctrl = 4'h9; id_rd = 4; id_we = 1;
        cyc("cap1");
        idle(); stall = 1; rd_regs(6, 7); id_ctrl = 4'h3; id_rd = 7;
        cyc("st1");
        wb(1, 32'h7F000000, 4'b1000);
        cyc("st2");
        chk("stall_opA", operA, 32'h7F020304);
        wb_en = 0;
        cyc("st3");
        chk("stall_opA_held", operA, 32'h7F020304);
        chk("stall_opB_held", operB, 32'hA1B2C3D4);
        chk("stall_ctrl", 32'(CtrlFunc), 32'h9);
        chk("stall_rd", 32'(ex_rd), 32'h4);
        chk("stall_valid", 32'(ex_valid), 32'h1);
        chk("stall_we", 32'(ex_we), 32'h1);

        flush = 1;
        cyc("fl");
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_we", 32'(ex_we), 32'h0);

        idle(); id_we = 1;
        cyc("bub");
        chk("bubble_valid", 32'(ex_valid), 32'h0);
        chk("bubble_we", 32'(ex_we), 32'h0);

        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_ctrl = 4'($urandom);
            id_ra = 3'($urandom); id_rb = 3'($urandom); id_rd = 3'($urandom);
            id_we = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            wb_en = 1'($urandom);
            wb_addr = 3'($urandom);
            wb_data = $urandom;
            wb_lane_mask = 4'($urandom);
            cyc("rnd");
        end

        idle(); rd_regs(2, 5); id_we = 1; id_ctrl = 4'hF; id_rd = 6;
        cyc("pre");
        stall = 1; wb(2, 32'hDEADBEEF, 4'b1111);
        #2 rst = 1;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'h0);
        chk("arst_we", 32'(ex_we), 32'h0);
        chk("arst_opA", operA, 32'h0);
        chk("arst_opB", operB, 32'h0);
        chk("arst_ctrl", 32'(CtrlFunc), 32'h0);
        chk("arst_rd", 32'(ex_rd), 32'h0);
        model_reset();
        @(posedge clk); #1;
        idle(); rst = 0;
        for (int r = 0; r < 8; r++) begin
            rd_regs(3'(r), 3'(r));
            cyc("post");
            chk("post_rf_zero", operA | operB, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vect_operand_stage.md
# vect_operand_stage

Vector operand-fetch stage that sits directly upstream of the 4-lane, 8-bit-per-lane vector ALU. It holds the vector register file and applies writeback-to-read bypass with per-lane masks. It registers `operA`, `operB` and `CtrlFunc` into the ID/EX pipeline register that drives the vector ALU, with stall and flush control.

## Interface
- `NREG`, default 8: number of 32-bit vector registers.
- `AW`, default 3: register address width; NREG = 2^AW.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode slot holds a valid vector instruction.
- `id_ctrl` in 4: ALU function code for that instruction.
- `id_ra`, `id_rb` in AW: source register indices.
- `id_rd` in AW: destination register index.
- `id_we` in 1: instruction writes a result.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: insert a bubble into ID/EX.
- `wb_en` in 1: writeback request from the downstream stage.
- `wb_addr` in AW: writeback register index.
- `wb_data` in 32: writeback data.
- `wb_lane_mask` in 4: per-lane write enables. Bit i covers bits [8i+7:8i]; bit 3 covers bits [31:24].
- `ex_valid` out 1: ID/EX holds a valid instruction.
- `operA`, `operB` out 32: operands to the vector ALU.
- `CtrlFunc` out 4: function code to the vector ALU.
- `ex_rd` out AW, `ex_we` out 1: destination info carried forward.

## Operation
- Register file:
  - NREG x 32 bits.
  - All entries are writable; there is no hardwired zero register.
  - Reset clears every entry to 0.
- Write:
  - On a rising edge with `wb_en`=1, lanes of `wb_addr` whose mask bit is 1 take `wb_data` lanes.
  - Other lanes are unchanged. Mask 4'b0000 writes nothing.
  - Writeback is independent of `stall`/`flush`.
- Read with bypass:
  - Combinational read of `id_ra`/`id_rb`.
  - If `wb_en`=1 and `wb_addr` equals the source index, masked lanes are replaced by `wb_data` lanes before capture.
  - `id_ra`==`id_rb` is legal; both operands get the same bypassed value.
- ID/EX register update, priority `flush` > `stall` > normal:
  - **flush=1:** `ex_valid`←0 and `ex_we`←0. Other fields are don't-care and are held.
  - **stall=1, flush=0:** all fields are held. While held, if `wb_en`=1 and `wb_addr` matches the held source index of A (or B), masked lanes of the held `operA` (or `operB`) are updated with `wb_data`. Held operands therefore never go stale. Internal registers `ex_ra`/`ex_rb` store the source indices for this purpose.
  - **Normal:**
    - `ex_valid`←`id_valid`.
    - `operA`/`operB`←bypassed reads.
    - `CtrlFunc`←`id_ctrl`, `ex_rd`←`id_rd`.
    - `ex_we`←`id_we`&`id_valid`.
    - `ex_ra`/`ex_rb`←indices.
- Arithmetic: none. Lanes are never mixed or shifted; per-lane merges only.

## Timing
- Latency: operands for an instruction presented in cycle N appear on `operA`/`operB` after the rising edge ending cycle N, i.e. valid in cycle N+1.
- Write visibility:
  - A writeback in cycle N is visible to a read in cycle N through the bypass.
  - It is visible from the array from cycle N+1.
- Reset:
  - Asserting `rst` immediately, without waiting for a clock edge, drives `ex_valid`, `ex_we`, `operA`, `operB`, `CtrlFunc` and `ex_rd` to 0.
  - The register file and internal `ex_ra`/`ex_rb` also clear to 0.
  - Release takes effect at the next rising edge.
- Reset mid-stall or mid-writeback: the in-flight write is dropped and all state is 0.
- `stall` and `flush` together: flush wins and `ex_valid`=0 after the edge.

## Test plan
- **Reset:** assert `rst` between edges -> all outputs 0 before the next edge. After release, read r3 -> `operA`=0x00000000 with `ex_valid`=1.
- **Full write:** r2←0xA1B2C3D4 with mask 4'b1111. Next cycle `id_ra`=2 -> `operA`=0xA1B2C3D4.
- **Bypass with partial mask:** r5=0xFFFFFFFF. In the same cycle, wb r5=0x11223344 with mask 4'b0101 and `id_ra`=`id_rb`=5 -> `operA`=`operB`=0xFF22FF44. A later read of r5 returns 0xFF22FF44.
- **Stall coherence:** capture `operA` from r1=0x01020304, then stall 3 cycles. In stall cycle 2, wb r1=0x7F000000 with mask 4'b1000 -> held `operA` becomes 0x7F020304. All other fields are held.
- **Flush vs stall:** `ex_valid`=1 with `stall`=1 and `flush`=1 -> `ex_valid`=0 and `ex_we`=0 next cycle.
- **Bubble:** `id_valid`=0 with `id_we`=1 -> `ex_valid`=0 and `ex_we`=0.
